// File: rtl/snd_cmd_mailbox.sv
// Sound command mailbox between the main CPU and the sound CPU.
// Each rising edge of SNDRQ pushes the byte on CPUDO into a small FIFO.
// Each rising edge of SRD pops the head entry.
// SNDDT presents the head entry to the sound CPU.
// A paced NMI sequencer raises one SNDNMI pulse per queued command.
// It also enforces a quiet gap after each pop before the next pulse.
module snd_cmd_mailbox #(
    parameter int DEPTH_LOG2 = 2,   // FIFO depth = 2**DEPTH_LOG2, must be >= 1
    parameter int NMI_LEN    = 16,  // NMI pulse width in clock cycles, >= 1
    parameter int GAP_LEN    = 64   // min cycles from a pop to the next NMI, >= 1
) (
    input  logic                  CLK48M,
    input  logic                  RESETn,
    input  logic                  SNDRQ,
    input  logic [7:0]            CPUDO,
    input  logic                  SRD,
    output logic [7:0]            SNDDT,
    output logic                  SNDNMI,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  OVF,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic [1:0]            dbg_state
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int MAX_LEN = (NMI_LEN > GAP_LEN) ? NMI_LEN : GAP_LEN;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [DEPTH_LOG2:0] DEPTH_C  = DEPTH[DEPTH_LOG2:0];
    localparam logic [CW-1:0]       NMI_LOAD = CW'(NMI_LEN - 1);
    localparam logic [CW-1:0]       GAP_LOAD = CW'(GAP_LEN - 1);

    // NMI sequencer states; the current state is mirrored on dbg_state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // no pulse pending, waiting for a queued command
        ST_PULSE = 2'd1,  // SNDNMI high, counting the pulse width
        ST_WAIT  = 2'd2,  // pulse done, waiting for the sound CPU to pop
        ST_GAP   = 2'd3   // post-pop quiet time before another pulse may start
    } nmi_state_t;

    // Request protocol: both CPU sides use level strobes.
    // Only the 0->1 transition seen at a clock edge counts as an event.
    // A push is taken when the queue has room after any same-edge pop.
    // A pop is taken only when the queue holds at least one entry.
    logic                    srq_q;
    logic                    srd_q;
    logic                    push_ev;
    logic                    pop_ev;
    logic                    pop_ok;
    logic                    push_ok;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2:0]     count_nxt;

    nmi_state_t              state;
    logic [CW-1:0]           tmr;
    logic                    pop_seen;

    assign push_ev = SNDRQ & ~srq_q;
    assign pop_ev  = SRD & ~srd_q;

    // Pop is judged first, so a full queue can accept a push on the same edge.
    assign pop_ok  = pop_ev & (COUNT != '0);
    assign push_ok = push_ev & ((COUNT != DEPTH_C) | pop_ok);

    assign dbg_state = state;

    // Next occupancy; a same-edge push and pop cancel out.
    always_comb begin
        count_nxt = COUNT;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = COUNT + 1'b1;
            2'b01:   count_nxt = COUNT - 1'b1;
            default: count_nxt = COUNT;
        endcase
    end

    // Edge-detect history for the two CPU strobes.
    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            srq_q <= 1'b0;
            srd_q <= 1'b0;
        end else begin
            srq_q <= SNDRQ;
            srd_q <= SRD;
        end
    end

    // Command storage; stale entries are harmless because COUNT gates reads.
    always_ff @(posedge CLK48M) begin
        if (push_ok) begin
            mem[wr_ptr] <= CPUDO;
        end
    end

    // Queue pointers, occupancy, status flags and the sticky overflow flag.
    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
            EMPTY  <= 1'b1;
            FULL   <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ev && !push_ok) begin
                OVF <= 1'b1;
            end
            COUNT <= count_nxt;
            EMPTY <= (count_nxt == '0);
            FULL  <= (count_nxt == DEPTH_C);
        end
    end

    // Head-of-queue register.
    // It follows the current head one edge later and freezes when the queue is empty.
    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            SNDDT <= 8'h00;
        end else if (COUNT != '0) begin
            SNDDT <= mem[rd_ptr];
        end
    end

    // NMI sequencer.
    // It emits one pulse per command, then waits for the pop and holds off for the gap.
    always_ff @(posedge CLK48M or negedge RESETn) begin
        if (!RESETn) begin
            state    <= ST_IDLE;
            SNDNMI   <= 1'b0;
            tmr      <= '0;
            pop_seen <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    SNDNMI <= 1'b0;
                    if (COUNT != '0) begin
                        state  <= ST_PULSE;
                        SNDNMI <= 1'b1;
                        tmr    <= NMI_LOAD;
                        // A pop on the launch edge already answers this pulse.
                        // Counting it avoids parking in WAIT with an empty queue.
                        pop_seen <= pop_ok;
                    end
                end
                ST_PULSE: begin
                    if (tmr == '0) begin
                        SNDNMI   <= 1'b0;
                        tmr      <= GAP_LOAD;
                        pop_seen <= 1'b0;
                        state    <= (pop_seen || pop_ok) ? ST_GAP : ST_WAIT;
                    end else begin
                        tmr <= tmr - 1'b1;
                        if (pop_ok) begin
                            pop_seen <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    SNDNMI <= 1'b0;
                    if (pop_ok) begin
                        tmr   <= GAP_LOAD;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    SNDNMI <= 1'b0;
                    if (tmr == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    SNDNMI <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/snd_cmd_mailbox.md
Name: snd_cmd_mailbox

Overview:
- Downstream of the main-CPU block. Captures each sound command the main CPU writes to I/O port 0x18 (SNDRQ qualifies the write; the byte is on CPUDO).
- Queues commands in a small FIFO and raises paced NMI pulses to the sound CPU.
- Presents the head command on a read port that the sound CPU pops.
- Replaces a bare single-byte latch so back-to-back commands are not lost.

Parameters:
- DEPTH_LOG2, 2: FIFO depth = 2**DEPTH_LOG2 entries.
- NMI_LEN, 16: NMI pulse width in CLK48M cycles; must be >= 1.
- GAP_LEN, 64: minimum CLK48M cycles from a pop to the next NMI; must be >= 1.

Ports:
- CLK48M, input, 1: the only clock.
- RESETn, input, 1: asynchronous, active-low reset.
- SNDRQ, input, 1: main-CPU sound write request. Level signal; may stay high for many CLK48M cycles.
- CPUDO, input, 8: main-CPU write data, valid while SNDRQ is high.
- SRD, input, 1: sound-CPU latch read. Level signal; each rising edge is one pop.
- SNDDT, output, 8: registered head-of-queue data for the sound CPU.
- SNDNMI, output, 1: NMI to the sound CPU, active high.
- EMPTY, output, 1: queue empty.
- FULL, output, 1: queue full.
- OVF, output, 1: sticky flag, set when a push is dropped.
- COUNT, output, DEPTH_LOG2+1: number of queued entries.

Behaviour:
- Reset values (asynchronous on RESETn=0): pointers 0, COUNT=0, EMPTY=1, FULL=0, OVF=0, SNDNMI=0, SNDDT=0x00, FSM=IDLE, edge-detect registers 0.
- Edge detection: SNDRQ and SRD are each registered once. push_ev = SNDRQ & ~SNDRQ_q; pop_ev = SRD & ~SRD_q. Both are evaluated at the same CLK48M edge.
- Pop: taken if COUNT>0 at that edge; read pointer increments and wraps modulo depth. A pop while empty is ignored; SNDDT holds its last value.
- Push: CPUDO is written at the write pointer, which increments and wraps.
  - Accepted if COUNT<depth, or if COUNT==depth and a valid pop occurs on the same edge (pop is evaluated first).
  - Otherwise the push is dropped: OVF<=1 until reset, and queue contents are unchanged.
- Simultaneous push and pop with COUNT>0: both happen, COUNT is unchanged.
- Push into an empty queue with a pop on the same edge: the pop is ignored and the push succeeds, so COUNT becomes 1.
- SNDDT: registered; equals the entry at the new read pointer one edge after any push or pop that changes the head.
  - Push into empty at edge k gives SNDDT=data from edge k+1.
  - A pop that leaves the queue empty leaves SNDDT holding the popped value.
- EMPTY, FULL and COUNT are registered and consistent with each other on every cycle.
- NMI FSM:
  - IDLE: if COUNT>0, go to PULSE, set SNDNMI=1 and load the counter with NMI_LEN-1.
  - PULSE: count down. At 0, clear SNDNMI and go to GAP if a pop was seen during PULSE, else go to WAIT.
  - WAIT: SNDNMI=0. On a valid pop, load the counter with GAP_LEN-1 and go to GAP.
  - GAP: count down. At 0, go to IDLE.
  - Consequences: one pulse per command; pulses never merge; NMI rises one edge after the push that makes COUNT>0 (registered decision on COUNT).
- Pushes never affect FSM timing except through COUNT.
- Reset asserted mid-pulse drops SNDNMI immediately (asynchronously) and discards all queued commands.

Test Plan:
- Reset, then SNDRQ high for 10 cycles with CPUDO=0x5A: exactly one push. COUNT=1, SNDDT=0x5A, SNDNMI high for exactly 16 cycles starting one cycle after COUNT becomes 1, then low.
- Push 0x11, 0x22, 0x33; pop via SRD after each NMI: SNDDT reads 0x11, 0x22, 0x33 in order. Three NMI pulses, each separated by at least 64 cycles after the preceding pop. EMPTY=1 at the end, SNDDT=0x33.
- Push 0x01..0x05 with no pops: COUNT=4, FULL=1, OVF=1. Pops yield 0x01..0x04; 0x05 is never seen.
- FULL queue with push 0xAA and pop on the same edge: COUNT stays 4, OVF stays 0, 0xAA is last out after four pops.
- Empty queue with SRD edge and SNDRQ edge (0x77) on the same cycle: COUNT=1, SNDDT=0x77, one NMI pulse.
- RESETn low during an NMI pulse with COUNT=3: SNDNMI=0, COUNT=0, SNDDT=0x00 immediately. No NMI after release until a new push.
